chain_emitter: RTL and testbench
================================

# chain_emitter

Parallel-to-chain serializer for ShadowCapture, driving the chain side that `chain_interpreter_tm` consumes. It accepts one snapshot word of CHAINS_OUT × CHAIN_DEPTH bits over a valid/ready handshake. It then shifts the word out as CHAINS_OUT parallel serial chains, one bit per chain per clock, with frame-delimiting strobes. It sits between the capture buffer and the chain port.

## Interface
- CHAINS_OUT, 3, number of parallel chains (≥1)
- CHAIN_DEPTH, 4, bits per chain per frame (≥2)
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- din  input  CHAINS_OUT*CHAIN_DEPTH  snapshot; chain c bit d = din[c*CHAIN_DEPTH + d]
- din_valid  input  1  din holds a frame
- din_ready  output  1  emitter accepts din this cycle
- cout  output  CHAINS_OUT  current chain bits; cout[c] = chain c
- cvalid  output  1  cout carries frame data (or parity, if enabled)
- cfirst  output  1  first bit (d=0) of a frame on cout
- clast  output  1  final cycle of a frame on cout
- busy  output  1  frame in flight (state ≠ IDLE)

## Operation
- Handshake: transfer when din_valid && din_ready. din is captured into a shift register. din is ignored at all other times.
- States:
  - IDLE: din_ready=1, cvalid=0. On transfer, go to SHIFT with idx=0.
  - SHIFT: cout[c] = sreg bit (c, idx), cvalid=1, cfirst=(idx==0).
    - idx<CHAIN_DEPTH-1: idx increments.
    - idx==CHAIN_DEPTH-1: clast=1 (without parity). The next state is SHIFT with idx=0 if a transfer occurs this cycle, otherwise IDLE.
  - PARITY (macro only): see Configuration.
- Bit order: d=0 is emitted first on every chain. All chains advance in lockstep.
- din_ready is 1 in IDLE and in the frame's final output cycle, and 0 otherwise. This gives back-to-back frames with no idle gap.
- idx counter width is $clog2(CHAIN_DEPTH). It never exceeds CHAIN_DEPTH-1 and wraps to 0 only on a back-to-back transfer.
- cout is 0 whenever cvalid=0.
- Reset mid-frame abandons the frame. There is no partial flush.

## Timing
- Reset values: din_ready=0 during the rst cycle, then 1 in the cycle after rst deasserts. cout=0, cvalid=0, cfirst=0, clast=0, busy=0.
- Latency: transfer at edge N means the first bit is on cout during cycle N+1. All outputs are registered.
- Frame length is CHAIN_DEPTH cycles, or CHAIN_DEPTH+1 with parity.
- Sustained throughput: one frame per CHAIN_DEPTH (+1) cycles when din_valid is held high.
- din_valid dropping while din_ready=0 has no effect. A frame once accepted always completes unless rst is asserted.
- rst asserted together with din_valid: reset wins and no transfer occurs.

## Configuration
- CHAIN_EMITTER_PARITY_EN defined:
  - After the d=CHAIN_DEPTH-1 cycle, the emitter enters PARITY for one cycle.
  - cout[c] = XOR of chain c's CHAIN_DEPTH bits (even parity), with cvalid=1 and clast=1.
  - din_ready=1 in PARITY, not in the last SHIFT cycle. PARITY exits to SHIFT or IDLE using the same rule as above.
- Undefined: no PARITY state. Frames are exactly CHAIN_DEPTH cycles and clast is on the last data bit.

## Test plan
- Reset: hold rst 2 cycles with din_valid=1 → no transfer. All outputs at their reset values. din_ready=1 in the first cycle after release.
- Single frame (CHAINS_OUT=3, CHAIN_DEPTH=4): din=12'hCE5, one-cycle valid → cout = 3'b001, 010, 111, 110 on four consecutive cycles. cfirst on 001 and clast on 110. The interpreter bench stimulus reproduces exactly.
- Back-to-back: din_valid held with 12'hCE5 then 12'h000 → eight contiguous cvalid cycles with no gap. cfirst at cycles 1 and 5, and din_ready high only at cycles 0, 4 and 8.
- Stall: din_valid toggled while busy → din is not re-sampled and output matches the first word only.
- Mid-frame reset: rst at the second data cycle → next cycle has cvalid=0 and cout=0. A new frame then starts cleanly with cfirst.
- CHAIN_EMITTER_PARITY_EN: din=12'hCE5 → after 110, a fifth cycle with cout=3'b010, clast=1. din_ready high in that cycle only.

Source files
------------

// File: rtl/chain_emitter.sv
// chain_emitter: parallel-to-chain serializer.
// Accepts one CHAINS_OUT x CHAIN_DEPTH snapshot word over a valid/ready
// handshake and emits it as CHAINS_OUT lockstep serial chains, bit d=0 first,
// with cfirst/clast frame strobes. All outputs are registered.
// Optional feature: define CHAIN_EMITTER_PARITY_EN to append one even-parity
// beat per chain after the last data bit of every frame.
module chain_emitter #(
    parameter int CHAINS_OUT  = 3,
    parameter int CHAIN_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHAINS_OUT*CHAIN_DEPTH-1:0] din,
    input  logic                             din_valid,
    output logic                             din_ready,
    output logic [CHAINS_OUT-1:0]            cout,
    output logic                             cvalid,
    output logic                             cfirst,
    output logic                             clast,
    output logic                             busy
);

    localparam int IW = $clog2(CHAIN_DEPTH);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(CHAIN_DEPTH - 1);

`ifdef CHAIN_EMITTER_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Even parity over one chain's bits.
    function automatic logic even_parity(input logic [CHAIN_DEPTH-1:0] bits);
        return ^bits;
    endfunction

    state_t state_r, state_n;
    logic [IW-1:0] idx_r, idx_n;
    logic load_s;
    logic xfer_s;

    // Per-chain views of the incoming word and of the holding register.
    logic [CHAINS_OUT-1:0][CHAIN_DEPTH-1:0] din_s;
    logic [CHAINS_OUT-1:0][CHAIN_DEPTH-1:0] din_shift_s;
    logic [CHAINS_OUT-1:0][CHAIN_DEPTH-1:0] sreg_r;
    logic [CHAINS_OUT-1:0][CHAIN_DEPTH-1:0] sreg_n;
    logic [CHAINS_OUT-1:0][CHAIN_DEPTH-1:0] sreg_shift_s;
    logic [CHAINS_OUT-1:0] din_col0_s;
    logic [CHAINS_OUT-1:0] sreg_col0_s;
    logic [CHAINS_OUT-1:0] din_par_s;
    logic [CHAINS_OUT-1:0] par_r, par_n;

    // Registered output copies and their next values.
    logic [CHAINS_OUT-1:0] cout_r, cout_n;
    logic cvalid_r, cvalid_n;
    logic cfirst_r, cfirst_n;
    logic clast_r, clast_n;
    logic ready_r, ready_n;
    logic busy_r, busy_n;

    assign din_s  = din;
    assign xfer_s = din_valid & ready_r;

    // The holding register keeps the not-yet-emitted bits of each chain,
    // right-aligned, so the next bit to emit is always bit 0.
    generate
        for (genvar g = 0; g < CHAINS_OUT; g++) begin : g_chain
            assign din_col0_s[g]   = din_s[g][0];
            assign din_shift_s[g]  = {1'b0, din_s[g][CHAIN_DEPTH-1:1]};
            assign sreg_col0_s[g]  = sreg_r[g][0];
            assign sreg_shift_s[g] = {1'b0, sreg_r[g][CHAIN_DEPTH-1:1]};
            assign din_par_s[g]    = even_parity(din_s[g]);
        end
    endgenerate

    // State register plus datapath and registered outputs; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= IDX_ZERO;
            sreg_r   <= {(CHAINS_OUT*CHAIN_DEPTH){1'b0}};
            par_r    <= {CHAINS_OUT{1'b0}};
            cout_r   <= {CHAINS_OUT{1'b0}};
            cvalid_r <= 1'b0;
            cfirst_r <= 1'b0;
            clast_r  <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            idx_r    <= idx_n;
            sreg_r   <= sreg_n;
            par_r    <= par_n;
            cout_r   <= cout_n;
            cvalid_r <= cvalid_n;
            cfirst_r <= cfirst_n;
            clast_r  <= clast_n;
            ready_r  <= ready_n;
            busy_r   <= busy_n;
        end
    end

    // Next-state logic: walk idx through the frame, optionally add a parity
    // beat, and restart immediately when a new word is taken on the final beat.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_n = ST_SHIFT;
                    idx_n   = IDX_ZERO;
                    load_s  = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (idx_r != IDX_LAST) begin
                    idx_n = idx_r + IDX_ONE;
                end else if (PARITY_EN) begin
                    state_n = ST_PARITY;
                end else if (xfer_s) begin
                    state_n = ST_SHIFT;
                    idx_n   = IDX_ZERO;
                    load_s  = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    idx_n   = IDX_ZERO;
                end
            end
            ST_PARITY: begin
                if (xfer_s) begin
                    state_n = ST_SHIFT;
                    idx_n   = IDX_ZERO;
                    load_s  = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    idx_n   = IDX_ZERO;
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = IDX_ZERO;
            end
        endcase
    end

    // Output logic: derive the values the outputs take in the next cycle
    // from the next state, so every port comes straight from a flop.
    always_comb begin
        cout_n   = {CHAINS_OUT{1'b0}};
        cvalid_n = 1'b0;
        cfirst_n = 1'b0;
        clast_n  = 1'b0;
        ready_n  = 1'b0;
        busy_n   = 1'b0;
        sreg_n   = sreg_r;
        par_n    = par_r;
        case (state_n)
            ST_IDLE: begin
                ready_n = 1'b1;
            end
            ST_SHIFT: begin
                cvalid_n = 1'b1;
                busy_n   = 1'b1;
                cfirst_n = (idx_n == IDX_ZERO);
                clast_n  = (!PARITY_EN) && (idx_n == IDX_LAST);
                ready_n  = (!PARITY_EN) && (idx_n == IDX_LAST);
                if (load_s) begin
                    cout_n = din_col0_s;
                    sreg_n = din_shift_s;
                    par_n  = din_par_s;
                end else begin
                    cout_n = sreg_col0_s;
                    sreg_n = sreg_shift_s;
                end
            end
            ST_PARITY: begin
                cout_n   = par_r;
                cvalid_n = 1'b1;
                clast_n  = 1'b1;
                ready_n  = 1'b1;
                busy_n   = 1'b1;
            end
            default: begin
                ready_n = 1'b0;
            end
        endcase
    end

    assign cout      = cout_r;
    assign cvalid    = cvalid_r;
    assign cfirst    = cfirst_r;
    assign clast     = clast_r;
    assign din_ready = ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_chain_emitter.sv
// Self-checking bench for chain_emitter: a frame-level reference model
// (queue of expected beats) compared every cycle, plus directed scenarios
// with hand-computed literal expectations.
module tb_chain_emitter;

    localparam int C = 3;
    localparam int D = 4;
    localparam int W = C * D;
`ifdef CHAIN_EMITTER_PARITY_EN
    localparam int FL  = D + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = D;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = {W{1'b0}};
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [C-1:0] cout;
    logic         cvalid, cfirst, clast, busy;

    always #5 clk = ~clk;

    chain_emitter #(.CHAINS_OUT(C), .CHAIN_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .cout(cout), .cvalid(cvalid),
        .cfirst(cfirst), .clast(clast), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    typedef struct {
        logic [C-1:0] bits;
        logic         first;
        logic         last;
    } beat_t;

    beat_t q[$];
    logic [C-1:0] e_cout = {C{1'b0}};
    logic e_cvalid = 1'b0, e_cfirst = 1'b0, e_clast = 1'b0;
    logic e_ready = 1'b0, e_busy = 1'b0;

    function automatic logic [C-1:0] column(input logic [W-1:0] w, input int d);
        logic [C-1:0] r;
        for (int c = 0; c < C; c++) r[c] = w[c*D + d];
        return r;
    endfunction

    function automatic logic [C-1:0] chain_parity(input logic [W-1:0] w);
        logic [C-1:0] r;
        for (int c = 0; c < C; c++) begin
            r[c] = 1'b0;
            for (int d = 0; d < D; d++) r[c] = r[c] ^ w[c*D + d];
        end
        return r;
    endfunction

    task automatic push_frame(input logic [W-1:0] w);
        beat_t b;
        for (int d = 0; d < D; d++) begin
            b.bits  = column(w, d);
            b.first = (d == 0);
            b.last  = (!PAR) && (d == D - 1);
            q.push_back(b);
        end
        if (PAR) begin
            b.bits  = chain_parity(w);
            b.first = 1'b0;
            b.last  = 1'b1;
            q.push_back(b);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: frames become queued beats; one beat shows per cycle.
    initial begin
        beat_t b;
        forever begin
            @(posedge clk);
            if (rst) begin
                armed = 1'b1;
                q.delete();
                e_cout = {C{1'b0}}; e_cvalid = 1'b0; e_cfirst = 1'b0;
                e_clast = 1'b0; e_ready = 1'b0; e_busy = 1'b0;
            end else begin
                if (din_valid && e_ready) push_frame(din);
                if (q.size() > 0) begin
                    b = q.pop_front();
                    e_cout = b.bits; e_cvalid = 1'b1;
                    e_cfirst = b.first; e_clast = b.last;
                end else begin
                    e_cout = {C{1'b0}}; e_cvalid = 1'b0;
                    e_cfirst = 1'b0; e_clast = 1'b0;
                end
                e_busy  = e_cvalid;
                e_ready = (q.size() == 0);
            end
            #1;
            if (armed) begin
                chk("model_cout",   cout,      e_cout);
                chk("model_cvalid", cvalid,    e_cvalid);
                chk("model_cfirst", cfirst,    e_cfirst);
                chk("model_clast",  clast,     e_clast);
                chk("model_ready",  din_ready, e_ready);
                chk("model_busy",   busy,      e_busy);
            end
        end
    end

    logic [C-1:0] exp_seq [5];
    logic [W-1:0] w1;

    // Directed scenarios followed by randomized traffic.
    initial begin
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b111;
        exp_seq[3] = 3'b110; exp_seq[4] = 3'b010;

        // Pin the model's column and parity extraction.
        for (int k = 0; k < D; k++) chk("pin_column", column(12'hCE5, k), exp_seq[k]);
        chk("pin_parity", chain_parity(12'hCE5), 3'b010);

        // Reset with din_valid high: nothing may be accepted.
        rst = 1'b1; din_valid = 1'b1; din = 12'hABC;
        repeat (2) @(negedge clk);
        chk("rst_ready",  din_ready, 1'b0);
        chk("rst_cvalid", cvalid,    1'b0);
        chk("rst_cout",   cout,      3'b000);
        chk("rst_busy",   busy,      1'b0);
        rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", din_ready, 1'b1);
        chk("idle_after_rst",  cvalid,    1'b0);

        // Single frame of 12'hCE5.
        din = 12'hCE5; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; din = W'($urandom);
        for (int k = 0; k < FL; k++) begin
            chk("single_cout",   cout,   exp_seq[k]);
            chk("single_cfirst", cfirst, (k == 0));
            chk("single_clast",  clast,  (k == FL - 1));
            chk("single_ready",  din_ready, (k == FL - 1));
            @(negedge clk);
        end
        chk("single_end_cvalid", cvalid, 1'b0);

        // Back-to-back frames with din_valid held.
        din = 12'hCE5; din_valid = 1'b1;
        @(negedge clk);
        din = 12'h000;
        for (int k = 0; k < 2 * FL; k++) begin
            chk("b2b_cvalid", cvalid, 1'b1);
            chk("b2b_cfirst", cfirst, ((k % FL) == 0));
            chk("b2b_ready",  din_ready, ((k % FL) == FL - 1));
            if (k == FL) din_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_end_cvalid", cvalid, 1'b0);
        chk("b2b_end_ready",  din_ready, 1'b1);

        // Stall: din_valid toggles with new data while a frame is in flight.
        w1 = W'($urandom);
        din = w1; din_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < D; k++) begin
            chk("stall_cout", cout, column(w1, k));
            din = W'($urandom);
            din_valid = ((k % 2) == 1);
            @(negedge clk);
        end
        din_valid = 1'b0;
        repeat (2 * FL + 2) @(negedge clk);

        // Reset during the second data cycle, then a clean restart.
        din = W'($urandom); din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cvalid", cvalid, 1'b0);
        chk("midrst_cout",   cout,   3'b000);
        chk("midrst_busy",   busy,   1'b0);
        rst = 1'b0;
        @(negedge clk);
        din = 12'hCE5; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        chk("restart_cfirst", cfirst, 1'b1);
        chk("restart_cout",   cout,   3'b001);
        repeat (FL + 1) @(negedge clk);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
            din       = W'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0;
        repeat (FL + 3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
